// File: rtl/cdec_ram_arbiter.sv
// cdec_ram_arbiter: shares the single-port CDEC RAM between core and debug.
// CPU has priority; a starvation counter forces debug slots during bursts.
module cdec_ram_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int CORE_MAX = 4
) (
  input  logic          Clk,
  input  logic          nReset,
  input  logic          CpuReq,
  input  logic          CpuWe,
  input  logic [AW-1:0] CpuAddr,
  input  logic [DW-1:0] CpuWData,
  output logic          CpuAck,
  output logic [DW-1:0] CpuRData,
  input  logic          DbgReq,
  input  logic          DbgWe,
  input  logic [AW-1:0] DbgAddr,
  input  logic [AW-1:0] DbgLen,
  input  logic [DW-1:0] DbgWData,
  output logic          DbgBeat,
  output logic [DW-1:0] DbgRData,
  output logic          DbgDone,
  output logic          DbgBusy,
  output logic [AW-1:0] RamAddr,
  output logic [DW-1:0] RamData,
  output logic          RamWe,
  input  logic [DW-1:0] RamQ
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [3:0] SMAX = 4'(CORE_MAX);

  state_t        state;
  state_t        state_nxt;
  logic          win_dbg;
  logic          beat_live;
  logic          dbg_req_q;
  logic          dir_reg;
  logic [AW-1:0] ptr_reg;
  logic [AW-1:0] cnt_reg;
  logic [3:0]    starve;

  logic dbg_start;
  logic dbg_abort;
  logic dbg_elig;
  logic arb;
  logic grant_dbg;
  logic grant_cpu;
  logic cpu_fin;
  logic dbg_fin;
  logic beat_ok;
  logic last_beat;

  assign dbg_start = DbgReq & ~dbg_req_q & ~DbgBusy;
  assign dbg_abort = DbgBusy & ~DbgReq;
  assign dbg_elig  = DbgBusy & DbgReq;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (grant_cpu | grant_dbg) state_nxt = ACC;
        else                       state_nxt = IDLE;
      end
      ACC:     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    arb       = (state != ACC);
    grant_dbg = arb & dbg_elig & (~CpuReq | (starve == SMAX));
    grant_cpu = arb & CpuReq & ~grant_dbg;
    cpu_fin   = (state == ACC) & ~win_dbg;
    dbg_fin   = (state == ACC) & win_dbg;
    // an aborted burst's in-flight beat must not touch the counters
    beat_ok   = dbg_fin & beat_live & ~dbg_abort;
    last_beat = beat_ok & (cnt_reg == AW'(1));
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      CpuAck    <= 1'b0;
      CpuRData  <= '0;
      DbgBeat   <= 1'b0;
      DbgRData  <= '0;
      DbgDone   <= 1'b0;
      DbgBusy   <= 1'b0;
      RamAddr   <= '0;
      RamData   <= '0;
      RamWe     <= 1'b0;
      win_dbg   <= 1'b0;
      beat_live <= 1'b0;
      dbg_req_q <= 1'b0;
      dir_reg   <= 1'b0;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      starve    <= '0;
    end else begin
      dbg_req_q <= DbgReq;
      CpuAck    <= cpu_fin;
      DbgBeat   <= dbg_fin;
      DbgDone   <= last_beat;
      if (cpu_fin) CpuRData <= RamQ;
      if (dbg_fin) DbgRData <= RamQ;

      RamWe <= 1'b0;
      if (grant_dbg) begin
        RamAddr <= ptr_reg;
        RamData <= DbgWData;
        RamWe   <= dir_reg;
      end else if (grant_cpu) begin
        RamAddr <= CpuAddr;
        RamData <= CpuWData;
        RamWe   <= CpuWe;
      end
      if (grant_cpu | grant_dbg) win_dbg <= grant_dbg;

      if (grant_dbg)                beat_live <= 1'b1;
      else if (dbg_fin | dbg_abort) beat_live <= 1'b0;

      unique case (1'b1)
        dbg_abort: begin
          DbgBusy <= 1'b0;
          ptr_reg <= '0;
          cnt_reg <= '0;
          dir_reg <= 1'b0;
        end
        dbg_start: begin
          DbgBusy <= 1'b1;
          ptr_reg <= DbgAddr;
          cnt_reg <= DbgLen;
          dir_reg <= DbgWe;
        end
        beat_ok: begin
          ptr_reg <= ptr_reg + AW'(1);
          cnt_reg <= cnt_reg - AW'(1);
          if (last_beat) DbgBusy <= 1'b0;
        end
        default: ;
      endcase

      if (dbg_abort | grant_dbg | last_beat)
        starve <= '0;
      else if (grant_cpu & DbgBusy & (starve != SMAX))
        starve <= starve + 4'd1;
    end
  end

endmodule

// File: tb/tb_cdec_ram_arbiter.sv
// tb_cdec_ram_arbiter: directed bench for the CDEC RAM arbiter.
// Owns a behavioural 256x8 RAM on the Ram* side of the DUT.
module tb_cdec_ram_arbiter;

  logic       Clk = 1'b0;
  logic       nReset = 1'b1;
  logic       CpuReq = 1'b0;
  logic       CpuWe = 1'b0;
  logic [7:0] CpuAddr = '0;
  logic [7:0] CpuWData = '0;
  logic       CpuAck;
  logic [7:0] CpuRData;
  logic       DbgReq = 1'b0;
  logic       DbgWe = 1'b0;
  logic [7:0] DbgAddr = '0;
  logic [7:0] DbgLen = '0;
  logic [7:0] DbgWData = '0;
  logic       DbgBeat;
  logic [7:0] DbgRData;
  logic       DbgDone;
  logic       DbgBusy;
  logic [7:0] RamAddr;
  logic [7:0] RamData;
  logic       RamWe;
  logic [7:0] RamQ;

  logic [7:0] mem [256];
  int vec = 0;
  int errs = 0;

  cdec_ram_arbiter #(.AW(8), .DW(8), .CORE_MAX(4)) dut (
    .Clk(Clk), .nReset(nReset),
    .CpuReq(CpuReq), .CpuWe(CpuWe),
    .CpuAddr(CpuAddr), .CpuWData(CpuWData),
    .CpuAck(CpuAck), .CpuRData(CpuRData),
    .DbgReq(DbgReq), .DbgWe(DbgWe),
    .DbgAddr(DbgAddr), .DbgLen(DbgLen),
    .DbgWData(DbgWData), .DbgBeat(DbgBeat),
    .DbgRData(DbgRData), .DbgDone(DbgDone),
    .DbgBusy(DbgBusy), .RamAddr(RamAddr),
    .RamData(RamData), .RamWe(RamWe),
    .RamQ(RamQ)
  );

  always #5 Clk = ~Clk;

  assign RamQ = mem[RamAddr];
  always @(posedge Clk) if (RamWe) mem[RamAddr] <= RamData;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [55:0] outs();
    return {CpuAck, CpuRData, DbgBeat, DbgRData,
            DbgDone, DbgBusy, RamAddr, RamData,
            RamWe, 7'd0};
  endfunction

  task automatic cpu_xfer(
    input  logic       we,
    input  logic [7:0] a,
    input  logic [7:0] d,
    output logic [7:0] rd,
    output int         lat,
    output int         wes,
    output logic       aok
  );
    logic got;
    got = 1'b0;
    CpuReq = 1'b1; CpuWe = we;
    CpuAddr = a; CpuWData = d;
    lat = 0; wes = 0; aok = 1'b1; rd = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      lat++;
      if (RamWe) begin
        wes++;
        if (RamAddr !== a) aok = 1'b0;
      end
      if (CpuAck) begin
        got = 1'b1;
        rd = CpuRData;
      end
    end
    CpuReq = 1'b0;
  endtask

  task automatic dbg_run(
    input  logic       we,
    input  logic [7:0] a,
    input  logic [7:0] l,
    input  int         mul,
    input  int         add,
    input  logic       chk,
    input  int         abort_after,
    output int         beats,
    output int         dones,
    output int         last,
    output int         rdbad
  );
    DbgWe = we; DbgAddr = a; DbgLen = l;
    DbgWData = 8'(add);
    DbgReq = 1'b1;
    beats = 0; dones = 0; last = -1; rdbad = 0;
    for (int c = 0; c < 1200 && DbgReq; c++) begin
      tick();
      if (DbgBeat) begin
        if (chk && DbgRData !== 8'(beats * mul + add))
          rdbad++;
        beats++;
        DbgWData = 8'(beats * mul + add);
        if (abort_after != 0 && beats == abort_after)
          DbgReq = 1'b0;
      end
      if (DbgDone) begin
        dones++;
        last = beats;
        DbgReq = 1'b0;
      end
    end
    DbgReq = 1'b0;
    repeat (6) begin
      tick();
      if (DbgBeat) beats++;
      if (DbgDone) dones++;
    end
  endtask

  task automatic test_reset();
    #2 nReset = 1'b0;
    #1;
    vec++;
    if (outs() !== '0) begin
      errs++;
      $display("FAIL reset_outs: got %h want 0", outs());
    end
    repeat (2) @(posedge Clk);
    #3 nReset = 1'b1;
    tick();
    tick();
    vec++;
    if (outs() !== '0) begin
      errs++;
      $display("FAIL idle_outs: got %h want 0", outs());
    end
  endtask

  task automatic test_cpu_rw();
    logic [7:0] rd;
    int lat, wes;
    logic aok;
    cpu_xfer(1'b1, 8'h10, 8'hA5, rd, lat, wes, aok);
    vec++;
    if (lat !== 2 || wes !== 1 || aok !== 1'b1) begin
      errs++;
      $display("FAIL cpu_wr: lat %0d we %0d aok %0b want 2 1 1",
               lat, wes, aok);
    end
    cpu_xfer(1'b0, 8'h10, 8'h00, rd, lat, wes, aok);
    vec++;
    if (lat !== 2 || wes !== 0 || rd !== 8'hA5) begin
      errs++;
      $display("FAIL cpu_rd: lat %0d we %0d rd %h want 2 0 a5",
               lat, wes, rd);
    end
  endtask

  task automatic test_dbg_wrap();
    int b, d, l, r;
    dbg_run(1'b1, 8'hFE, 8'd4, 1, 1, 1'b0, 0, b, d, l, r);
    vec++;
    if (b !== 4 || d !== 1 || l !== 4) begin
      errs++;
      $display("FAIL wrap_beats: beats %0d done %0d at %0d want 4 1 4",
               b, d, l);
    end
    vec++;
    if ({mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]}
        !== 32'h01020304) begin
      errs++;
      $display("FAIL wrap_ram: got %h %h %h %h want 01 02 03 04",
               mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]);
    end
    vec++;
    if (DbgBusy !== 1'b0) begin
      errs++;
      $display("FAIL wrap_busy: got %b want 0", DbgBusy);
    end
  endtask

  task automatic test_dbg_full();
    int b, d, l, r;
    dbg_run(1'b1, 8'h00, 8'd0, 7, 3, 1'b0, 0, b, d, l, r);
    vec++;
    if (b !== 256 || d !== 1 || l !== 256) begin
      errs++;
      $display("FAIL full_wr: beats %0d done %0d at %0d want 256 1 256",
               b, d, l);
    end
    dbg_run(1'b0, 8'h00, 8'd0, 7, 3, 1'b1, 0, b, d, l, r);
    vec++;
    if (b !== 256 || d !== 1 || l !== 256) begin
      errs++;
      $display("FAIL full_rd: beats %0d done %0d at %0d want 256 1 256",
               b, d, l);
    end
    vec++;
    if (r !== 0) begin
      errs++;
      $display("FAIL full_rdata: bad words %0d want 0", r);
    end
  endtask

  task automatic test_starve();
    string got;
    string exp;
    int n, nd, dpos;
    got = "";
    exp = "CCCCCDCCCCDCCCCD";
    n = 0; nd = 0; dpos = -1;
    CpuWe = 1'b0; CpuAddr = 8'h20;
    DbgWe = 1'b1; DbgAddr = 8'h80; DbgLen = 8'd3;
    DbgWData = 8'h11;
    CpuReq = 1'b1;
    DbgReq = 1'b1;
    for (int c = 0; c < 200 && n < 16; c++) begin
      tick();
      if (CpuAck) begin
        got = {got, "C"};
        n++;
      end
      if (DbgBeat) begin
        got = {got, "D"};
        n++;
        nd++;
        DbgWData = 8'(8'h11 * (nd + 1));
      end
      if (DbgDone) begin
        dpos = n;
        DbgReq = 1'b0;
      end
    end
    CpuReq = 1'b0;
    DbgReq = 1'b0;
    repeat (3) tick();
    vec++;
    if (got != exp) begin
      errs++;
      $display("FAIL starve_seq: got %s want %s", got, exp);
    end
    vec++;
    if (dpos !== 16 || DbgBusy !== 1'b0) begin
      errs++;
      $display("FAIL starve_done: at %0d busy %b want 16 0",
               dpos, DbgBusy);
    end
    vec++;
    if ({mem[8'h80], mem[8'h81], mem[8'h82]} !== 24'h112233) begin
      errs++;
      $display("FAIL starve_ram: got %h %h %h want 11 22 33",
               mem[8'h80], mem[8'h81], mem[8'h82]);
    end
  endtask

  task automatic test_abort();
    int b, d, l, r;
    logic [7:0] rd;
    int lat, wes;
    logic aok;
    dbg_run(1'b1, 8'h30, 8'd8, 1, 8'h50, 1'b0, 2, b, d, l, r);
    vec++;
    if (b < 2 || b > 3 || d !== 0 || DbgBusy !== 1'b0) begin
      errs++;
      $display("FAIL abort: beats %0d done %0d busy %b want 2..3 0 0",
               b, d, DbgBusy);
    end
    cpu_xfer(1'b0, 8'h30, 8'h00, rd, lat, wes, aok);
    vec++;
    if (lat !== 2 || rd !== 8'h50) begin
      errs++;
      $display("FAIL abort_cpu: lat %0d rd %h want 2 50", lat, rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] old;
    logic [7:0] rd;
    int lat, wes, acks;
    logic aok;
    old = mem[8'h40];
    acks = 0;
    CpuReq = 1'b1; CpuWe = 1'b1;
    CpuAddr = 8'h40; CpuWData = ~old;
    tick();
    vec++;
    if (RamWe !== 1'b1) begin
      errs++;
      $display("FAIL rst_acc_we: got %b want 1", RamWe);
    end
    #2 nReset = 1'b0;
    #1;
    vec++;
    if (outs() !== '0) begin
      errs++;
      $display("FAIL rst_mid_outs: got %h want 0", outs());
    end
    CpuReq = 1'b0;
    repeat (2) @(posedge Clk);
    #3 nReset = 1'b1;
    repeat (5) begin
      tick();
      if (CpuAck) acks++;
    end
    vec++;
    if (acks !== 0 || mem[8'h40] !== old) begin
      errs++;
      $display("FAIL rst_abort: acks %0d ram %h want 0 %h",
               acks, mem[8'h40], old);
    end
    cpu_xfer(1'b1, 8'h41, 8'h5C, rd, lat, wes, aok);
    cpu_xfer(1'b0, 8'h41, 8'h00, rd, lat, wes, aok);
    vec++;
    if (lat !== 2 || rd !== 8'h5C) begin
      errs++;
      $display("FAIL rst_after: lat %0d rd %h want 2 5c", lat, rd);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_rw();
    test_dbg_wrap();
    test_dbg_full();
    test_starve();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
